// File: rtl/mipi_frame_writer.sv
// CSI-2 RAW8 word stream to framebuffer writer: crops each frame to H_WORDS x V_LINES
// and issues registered RAM writes at base + word, with base advanced per line.
module mipi_frame_writer #(
    parameter int H_WORDS = 160,
    parameter int V_LINES = 480,
    parameter int ADDR_W  = 17
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              line_start,
    input  logic              line_end,
    input  logic              pix_valid,
    input  logic [31:0]       pix_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              frame_done,
    output logic              line_err,
    output logic [9:0]        line_count
);
    // state     | meaning
    // IDLE      | no frame being captured; waits for frame_start with enable
    // WAIT_LINE | inside a captured frame, between long packets
    // IN_LINE   | receiving the words of one line

    typedef enum logic [1:0] {IDLE, WAIT_LINE, IN_LINE} state_t;

    localparam int                WORD_W = $clog2(H_WORDS + 1);
    localparam logic [WORD_W-1:0] H_LIM  = WORD_W'(H_WORDS);
    localparam logic [9:0]        V_LIM  = 10'(V_LINES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_WORDS);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   base, base_nxt, wbase;
    logic [WORD_W-1:0]   word, word_nxt, wword, word_inc;
    logic [9:0]          count_nxt, wcount, count_inc;
    logic                err_nxt, done_nxt, wen_nxt, take;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [31:0]         data_nxt;

    assign count_inc = (line_count == 10'h3FF) ? line_count : line_count + 10'd1;
    assign word_inc  = (word == H_LIM) ? word : word + WORD_W'(1);

    always_comb begin
        state_nxt = state;
        base_nxt  = base;
        word_nxt  = word;
        count_nxt = line_count;
        err_nxt   = line_err;
        done_nxt  = 1'b0;
        wen_nxt   = 1'b0;
        addr_nxt  = wr_addr;
        data_nxt  = wr_data;
        wbase     = base;
        wword     = word;
        wcount    = line_count;
        take      = 1'b0;

        if (state != IDLE && frame_start) begin
            // aborted frame: no frame_done, restart only when still enabled
            state_nxt = enable ? WAIT_LINE : IDLE;
            if (enable) begin
                base_nxt  = '0;
                count_nxt = '0;
                err_nxt   = 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start && enable) begin
                        state_nxt = WAIT_LINE;
                        base_nxt  = '0;
                        count_nxt = '0;
                        err_nxt   = 1'b0;
                    end
                end
                WAIT_LINE: begin
                    if (frame_end) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b0 | 1'b1;
                    end else if (line_start) begin
                        state_nxt = IN_LINE;
                        wword     = '0;
                        take      = pix_valid;
                        word_nxt  = pix_valid ? WORD_W'(1) : '0;
                    end
                end
                IN_LINE: begin
                    if (line_start && !line_end && !frame_end) begin
                        // unterminated line: close it and open the next one this cycle
                        err_nxt   = 1'b1;
                        wbase     = base + H_STEP;
                        wcount    = count_inc;
                        wword     = '0;
                        take      = pix_valid;
                        base_nxt  = wbase;
                        count_nxt = wcount;
                        word_nxt  = pix_valid ? WORD_W'(1) : '0;
                    end else begin
                        take = pix_valid;
                        if (line_end || frame_end) begin
                            base_nxt  = base + H_STEP;
                            count_nxt = count_inc;
                            word_nxt  = '0;
                            if (frame_end) begin
                                state_nxt = IDLE;
                                done_nxt  = 1'b1;
                            end else if (!line_start) begin
                                state_nxt = WAIT_LINE;
                            end
                        end else if (pix_valid) begin
                            word_nxt = word_inc;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (take && wword < H_LIM && wcount < V_LIM) begin
            wen_nxt  = 1'b1;
            addr_nxt = wbase + ADDR_W'(wword);
            data_nxt = pix_data;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            base       <= '0;
            word       <= '0;
            line_count <= '0;
            line_err   <= 1'b0;
            frame_done <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state      <= state_nxt;
            base       <= base_nxt;
            word       <= word_nxt;
            line_count <= count_nxt;
            line_err   <= err_nxt;
            frame_done <= done_nxt;
            wr_en      <= wen_nxt;
            wr_addr    <= addr_nxt;
            wr_data    <= data_nxt;
        end
    end
endmodule

// File: tb/tb_mipi_frame_writer.sv
// Bench for mipi_frame_writer on a reduced 8x6 geometry: frame table plus
// hand-written error/reset sequences, writes checked against a queue model.
module tb_mipi_frame_writer;
    localparam int H  = 8;
    localparam int V  = 6;
    localparam int AW = 6;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          frame_start = 1'b0, frame_end = 1'b0, line_start = 1'b0, line_end = 1'b0;
    logic          pix_valid = 1'b0;
    logic [31:0]   pix_data = '0;
    logic          wr_en, frame_done, line_err;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [9:0]    line_count;

    int total = 0, bad = 0;
    int wr_cnt = 0, done_cnt = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic en;
        int   nl;
        int   fw;
        int   ow;
        int   exp_wr;
        int   exp_lc;
        int   exp_done;
    } row_t;
    row_t rows[7];

    always #5 sys_clk = ~sys_clk;

    mipi_frame_writer #(.H_WORDS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .sys_clk(sys_clk), .reset(reset), .enable(enable),
        .frame_start(frame_start), .frame_end(frame_end),
        .line_start(line_start), .line_end(line_end),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .line_err(line_err), .line_count(line_count)
    );

    always @(negedge sys_clk) begin
        if (wr_en) begin
            wr_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%h", wr_addr, wr_data);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.addr !== wr_addr || mon_e.data !== wr_data) begin
                    bad++;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                             wr_addr, wr_data, mon_e.addr, mon_e.data);
                end
            end
        end
        if (frame_done) begin
            done_cnt++;
            if (prev_done) begin
                total++;
                bad++;
                $display("FAIL done_width frame_done high 2 cycles got=1 want=0");
            end
        end
        prev_done = frame_done;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        line_start  = 1'b0;
        line_end    = 1'b0;
        pix_valid   = 1'b0;
    endtask

    task automatic drive_word(input int line, input int w, input logic expect_wr);
        logic [31:0] d;
        exp_t e;
        d = $urandom;
        pix_data  = d;
        pix_valid = 1'b1;
        if (expect_wr && line < V && w < H) begin
            e.addr = AW'(line * H + w);
            e.data = d;
            sb.push_back(e);
        end
    endtask

    task automatic run_frame(input logic en, input int nl, input int fw, input int ow);
        int n;
        enable = en;
        frame_start = 1'b1;
        step();
        for (int l = 0; l < nl; l++) begin
            n = (l == 0) ? fw : ow;
            line_start = 1'b1;
            step();
            for (int w = 0; w < n; w++) begin
                drive_word(l, w, en);
                if (w == n - 1) line_end = 1'b1;
                step();
            end
            if (n == 0) begin
                line_end = 1'b1;
                step();
            end
        end
        frame_end = 1'b1;
        step();
        step();
        step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0;
        rows[0] = '{1'b1, 6,    8,  8,  48, 6,    1};
        rows[1] = '{1'b1, 2,    11, 11, 16, 2,    1};
        rows[2] = '{1'b1, 2,    5,  8,  13, 2,    1};
        rows[3] = '{1'b1, 8,    8,  8,  48, 8,    1};
        rows[4] = '{1'b0, 3,    8,  8,  0,  8,    0};
        rows[5] = '{1'b1, 1030, 1,  1,  6,  1023, 1};
        rows[6] = '{1'b1, 0,    0,  0,  0,  0,    1};

        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_line_err", line_err, 0);
        chk("rst_line_count", line_count, 0);
        @(posedge sys_clk);
        #1;
        reset = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            w0 = wr_cnt;
            d0 = done_cnt;
            run_frame(rows[i].en, rows[i].nl, rows[i].fw, rows[i].ow);
            chk($sformatf("row%0d_writes", i), wr_cnt - w0, rows[i].exp_wr);
            chk($sformatf("row%0d_line_count", i), line_count, rows[i].exp_lc);
            chk($sformatf("row%0d_frame_done", i), done_cnt - d0, rows[i].exp_done);
            chk($sformatf("row%0d_line_err", i), line_err, 0);
            chk($sformatf("row%0d_sb_empty", i), sb.size(), 0);
        end

        // second line_start without line_end
        enable = 1'b1;
        frame_start = 1'b1;
        step();
        line_start = 1'b1;
        step();
        for (int w = 0; w < 3; w++) begin
            drive_word(0, w, 1'b1);
            step();
        end
        line_start = 1'b1;
        drive_word(1, 0, 1'b1);
        step();
        for (int w = 1; w < 3; w++) begin
            drive_word(1, w, 1'b1);
            step();
        end
        line_end = 1'b1;
        step();
        step();
        chk("dup_line_err", line_err, 1);
        chk("dup_line_count", line_count, 2);
        d0 = done_cnt;
        frame_end = 1'b1;
        step();
        step();
        chk("dup_frame_done", done_cnt - d0, 1);
        chk("dup_err_sticky", line_err, 1);
        frame_start = 1'b1;
        step();
        step();
        chk("dup_err_cleared", line_err, 0);
        chk("dup_count_cleared", line_count, 0);
        frame_end = 1'b1;
        step();
        step();
        chk("dup_sb_empty", sb.size(), 0);

        // asynchronous reset in the middle of a line
        w0 = wr_cnt;
        frame_start = 1'b1;
        step();
        line_start = 1'b1;
        step();
        for (int w = 0; w < 3; w++) begin
            drive_word(0, w, 1'b1);
            step();
        end
        drive_word(0, 3, 1'b0);
        step();
        chk("pre_reset_wr_en", wr_en, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_reset_wr_en", wr_en, 0);
        chk("mid_reset_line_count", line_count, 0);
        chk("mid_reset_wr_addr", wr_addr, 0);
        step();
        reset = 1'b1;
        step();
        line_start = 1'b1;
        step();
        for (int w = 0; w < 4; w++) begin
            drive_word(0, w, 1'b0);
            if (w == 3) line_end = 1'b1;
            step();
        end
        d0 = done_cnt;
        frame_end = 1'b1;
        step();
        step();
        chk("post_reset_no_writes", wr_cnt - w0, 3);
        chk("post_reset_no_done", done_cnt - d0, 0);
        w0 = wr_cnt;
        run_frame(1'b1, 1, 4, 4);
        chk("restart_writes", wr_cnt - w0, 4);
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
